// File: rtl/sft_rr_sched.sv
// Round-robin arbiter sharing one 16-bit arithmetic right shifter across N_REQ lanes, result tagged with lane ID.
// Latency: 2 cycles from handshake to out_valid (issue reg -> comb shifter -> out reg), 1 op/cycle sustained.
// Backpressure: out_ready low stalls OUT, then ISSUE, then withholds req_ready; at most 2 ops in flight, none dropped.
module sft_rr_sched #(
    parameter int N_REQ   = 4,
    parameter int D_WIDTH = 16,
    parameter int AMT_W   = 5,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    input  logic [N_REQ*AMT_W-1:0]     req_amt,
    output logic [N_REQ-1:0]           req_ready,
    output logic [D_WIDTH-1:0]         sft_x,
    output logic                       sft_sign,
    output logic [5:0]                 sft_sel,
    input  logic [D_WIDTH-1:0]         sft_y,
    output logic                       out_valid,
    output logic [D_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]            out_id,
    input  logic                       out_ready
);

    typedef struct packed {
        logic [D_WIDTH-1:0] x;
        logic [AMT_W-1:0]   amt;
        logic [ID_W-1:0]    id;
    } iss_t;

    logic               iss_v;
    iss_t               iss_q;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_nxt;

    logic               out_adv;
    logic               iss_adv;
    logic               found;
    logic [ID_W-1:0]    win;
    logic [ID_W:0]      cand_sum;
    logic               hs;

    logic [D_WIDTH-1:0] lane_data [N_REQ];
    logic [AMT_W-1:0]   lane_amt  [N_REQ];

    // OUT frees up when empty or being drained; ISSUE can move whenever OUT can take it.
    assign out_adv = !out_valid || out_ready;
    assign iss_adv = !iss_v || out_adv;

    // Slice the flat request buses into per-lane operands.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lane_data[i] = req_data[i*D_WIDTH +: D_WIDTH];
            lane_amt[i]  = req_amt[i*AMT_W +: AMT_W];
        end
    end

    // Round-robin search: first valid lane at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand_sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand_sum >= (ID_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(N_REQ);
            end
            if (!found && req_valid[cand_sum[ID_W-1:0]]) begin
                found = 1'b1;
                win   = cand_sum[ID_W-1:0];
            end
        end
    end

    // Grant is suppressed during reset so no lane sees a handshake that will be discarded.
    assign hs     = found && iss_adv && rst_n;
    assign rr_nxt = (win == ID_W'(N_REQ-1)) ? '0 : win + ID_W'(1);

    // One-hot grant to the winner, only when the issue stage can accept.
    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[win] = 1'b1;
        end
    end

    // Issue stage: capture the granted request, advance the pointer past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_v  <= 1'b0;
            iss_q  <= '0;
            rr_ptr <= '0;
        end else if (hs) begin
            iss_v  <= 1'b1;
            iss_q  <= '{x: lane_data[win], amt: lane_amt[win], id: win};
            rr_ptr <= rr_nxt;
        end else if (iss_adv) begin
            iss_v  <= 1'b0;
        end
    end

    // Shifter drive; amounts of 16 and above collapse to the all-sign-bits select.
    assign sft_x    = iss_q.x;
    assign sft_sign = iss_q.x[D_WIDTH-1];
    assign sft_sel  = {1'b0, |iss_q.amt[AMT_W-1:4], iss_q.amt[3:0]};

    // Output stage: capture the shifter result with its lane tag; hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (out_adv) begin
            out_valid <= iss_v;
            if (iss_v) begin
                out_data <= sft_y;
                out_id   <= iss_q.id;
            end
        end
    end

endmodule

// File: tb/tb_sft_rr_sched.sv
// Bench for sft_rr_sched: behavioural shifter, transaction-level scoreboard, directed tables and corner sequences.
// Latency: expects results 2 cycles after grant with out_ready high.
// Backpressure: out_ready driven low in directed stalls and randomly in the soak phase.
module tb_sft_rr_sched;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 5;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N*AW-1:0] req_amt;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   sft_x;
    logic            sft_sign;
    logic [5:0]      sft_sel;
    logic [DW-1:0]   sft_y;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sft_rr_sched #(.N_REQ(N), .D_WIDTH(DW), .AMT_W(AW), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_amt(req_amt), .req_ready(req_ready),
        .sft_x(sft_x), .sft_sign(sft_sign), .sft_sel(sft_sel), .sft_y(sft_y),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready)
    );

    // External shifter: sel[4] selects all sign bits, else shift {sign,x} right by sel[3:0].
    logic signed [DW:0] sh_ext;
    always_comb begin
        sh_ext = {sft_sign, sft_x};
        sh_ext = sh_ext >>> sft_sel[3:0];
        sft_y  = sft_sel[4] ? {DW{sft_sign}} : sh_ext[DW-1:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: arithmetic right shift as floor division by 2^amt on the signed value.
    function automatic logic [15:0] ref_shift(input logic [15:0] x, input int amt);
        int v;
        int r;
        v = x[15] ? int'(x) - 65536 : int'(x);
        if (amt >= 16) return x[15] ? 16'hFFFF : 16'h0000;
        if (v >= 0) r = v >> amt;
        else        r = -((-v - 1) >> amt) - 1;
        return r[15:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic [15:0] d, input logic [4:0] a);
        req_data[lane*DW +: DW] = d;
        req_amt[lane*AW +: AW]  = a;
    endtask

    // Scoreboard: accepted-but-undelivered ops in a queue, round-robin pointer as an integer.
    typedef struct { logic [15:0] d; logic [IW-1:0] id; } exp_t;
    exp_t          q[$];
    int            m_ptr = 0;
    int            w;
    int            idx;
    logic          acc;
    logic [N-1:0]  exp_rdy;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic [IW-1:0] prev_id;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ptr      = 0;
            prev_stall = 1'b0;
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_data", 32'(out_data), 32'h0);
            chk("rst_out_id", 32'(out_id), 32'h0);
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && req_valid[idx]) w = idx;
            end
            // Two in flight means both stages full; only a draining output frees a slot.
            acc     = (w >= 0) && (q.size() < 2 || out_ready);
            exp_rdy = '0;
            if (acc) exp_rdy[w] = 1'b1;
            chk("grant", 32'(req_ready), 32'(exp_rdy));
            chk("sel5_zero", 32'(sft_sel[5]), 32'h0);
            if (prev_stall) begin
                chk("hold_data", 32'(out_data), 32'(prev_d));
                chk("hold_id", 32'(out_id), 32'(prev_id));
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_id    = out_id;
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_result: got out_valid=1 id=%0d expected no op in flight", out_id);
                end else if (out_ready) begin
                    chk("sb_out_data", 32'(out_data), 32'(q[0].d));
                    chk("sb_out_id", 32'(out_id), 32'(q[0].id));
                    void'(q.pop_front());
                end
            end
            if (acc) begin
                q.push_back('{d: ref_shift(req_data[w*DW +: DW], int'(req_amt[w*AW +: AW])), id: IW'(w)});
                m_ptr = (w + 1) % N;
            end
        end
    end

    typedef struct {
        int          lane;
        logic [15:0] d;
        logic [4:0]  amt;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[8];

    int          n_hs;
    logic [15:0] frz_d;
    logic [IW-1:0] frz_id;

    initial begin
        tbl[0] = '{lane: 0, d: 16'h8000, amt: 5'd3,  exp: 16'hF000};
        tbl[1] = '{lane: 2, d: 16'h7FF0, amt: 5'd4,  exp: 16'h07FF};
        tbl[2] = '{lane: 2, d: 16'h8001, amt: 5'd20, exp: 16'hFFFF};
        tbl[3] = '{lane: 2, d: 16'h1234, amt: 5'd16, exp: 16'h0000};
        tbl[4] = '{lane: 2, d: 16'h1234, amt: 5'd0,  exp: 16'h1234};
        tbl[5] = '{lane: 1, d: 16'hFFFF, amt: 5'd31, exp: 16'hFFFF};
        tbl[6] = '{lane: 1, d: 16'h4000, amt: 5'd15, exp: 16'h0000};
        tbl[7] = '{lane: 3, d: 16'h8000, amt: 5'd15, exp: 16'hFFFF};

        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_amt   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b1;
        repeat (2) cyc();

        // Single-lane vectors: immediate grant, nothing at t+1, result at t+2.
        for (int i = 0; i < 8; i++) begin
            set_lane(tbl[i].lane, tbl[i].d, tbl[i].amt);
            req_valid = '0;
            req_valid[tbl[i].lane] = 1'b1;
            @(negedge clk);
            chk("tbl_grant", 32'(req_ready), 32'(1) << tbl[i].lane);
            cyc();
            req_valid = '0;
            @(negedge clk);
            chk("tbl_lat_t1", 32'(out_valid), 32'h0);
            @(negedge clk);
            chk("tbl_lat_t2", 32'(out_valid), 32'h1);
            chk("tbl_data", 32'(out_data), 32'(tbl[i].exp));
            chk("tbl_id", 32'(out_id), 32'(tbl[i].lane));
            repeat (2) cyc();
        end

        // Full load from pointer 0: back-to-back results 0,1,2,3,0,...
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("load_valid", 32'(out_valid), (c >= 2) ? 32'h1 : 32'h0);
            if (c >= 2) chk("load_id", 32'(out_id), 32'((c - 2) % N));
            cyc();
            req_data = {$urandom, $urandom};
            req_amt  = 20'($urandom);
        end
        req_valid = '0;
        repeat (3) cyc();

        // Move pointer to 2 by granting lane 1 alone, then alternate between lanes 3 and 1.
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        repeat (3) cyc();
        req_valid = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("rr13_grant", 32'(req_ready), (j % 2 == 0) ? 32'h8 : 32'h2);
            cyc();
        end
        req_valid = '0;
        repeat (3) cyc();

        // Output stall under full load: two ops accepted, output frozen, then drained in order.
        req_valid = '1;
        out_ready = 1'b0;
        n_hs      = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (req_ready != '0) n_hs++;
            if (c == 2) begin
                frz_d  = out_data;
                frz_id = out_id;
                chk("stall_valid", 32'(out_valid), 32'h1);
            end
            if (c == 3) begin
                chk("stall_frz_data", 32'(out_data), 32'(frz_d));
                chk("stall_frz_id", 32'(out_id), 32'(frz_id));
            end
            cyc();
        end
        chk("stall_accepted", 32'(n_hs), 32'h2);
        req_valid = '0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("stall_drained", 32'(q.size()), 32'h0);

        // Reset with two ops in flight: output drops at once, nothing emerges, lane 0 wins first.
        req_valid = '1;
        out_ready = 1'b0;
        repeat (2) cyc();
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_flush", 32'(out_valid), 32'h0);
        repeat (2) cyc();
        rst_n     = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_ghost", 32'(out_valid), 32'h0);
            cyc();
        end
        req_valid = '1;
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        repeat (3) cyc();

        // Randomised soak against the scoreboard.
        for (int c = 0; c < 800; c++) begin
            req_valid = N'($urandom);
            req_data  = {$urandom, $urandom};
            req_amt   = 20'($urandom);
            out_ready = ($urandom % 4) != 0;
            cyc();
        end
        req_valid = '0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("soak_drained", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
